// File: rtl/spell_trace_sequencer_pkg.sv
// Shared definitions for the spell-trace round controller: FSM state codes,
// power-up mode encoding, default point values and the per-stroke amount rule.
package spell_trace_sequencer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRACE  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'd0,
        MODE_BONUS  = 2'd1,
        MODE_DOUBLE = 2'd2
    } power_mode_e;

    localparam int unsigned DEF_POS_POINTS   = 300;
    localparam int unsigned DEF_NEG_POINTS   = 100;
    localparam int unsigned DEF_BONUS_POINTS = 150;

    // Magnitude of the command for one stroke; the add/subtract direction is the hit bit.
    function automatic logic [31:0] stroke_amount(
        input logic        hit,
        input logic [1:0]  mode,
        input logic [31:0] pos,
        input logic [31:0] neg,
        input logic [31:0] bonus
    );
        logic [31:0] amt;
        amt = neg;
        if (hit) begin
            case (mode)
                MODE_BONUS:  amt = pos + bonus;
                MODE_DOUBLE: amt = pos + pos;
                default:     amt = pos;
            endcase
        end
        return amt;
    endfunction

endpackage

// File: rtl/spell_trace_sequencer_power_timer.sv
// Power-up mode register with a sample-driven down-counter; the mode
// falls back to none when the counter runs out.
module spell_trace_sequencer_power_timer
    import spell_trace_sequencer_pkg::*;
#(
    parameter int unsigned POWER_SAMPLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [1:0] load_mode,
    input  logic       dec,
    output logic [1:0] mode
);

    logic [7:0] count;

    // A load wins over a decrement so a request in a sampling cycle keeps its full count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode  <= MODE_NONE;
            count <= 8'd0;
        end else if (clear) begin
            mode  <= MODE_NONE;
            count <= 8'd0;
        end else if (load) begin
            mode  <= load_mode;
            count <= 8'(POWER_SAMPLES);
        end else if (dec && count != 8'd0) begin
            count <= count - 8'd1;
            if (count == 8'd1) begin
                mode <= MODE_NONE;
            end
        end
    end

endmodule

// File: rtl/spell_trace_sequencer.sv
// Round controller: counts strokes and hits for one round and issues one
// registered add/subtract command per sampled stroke to the accumulator.
module spell_trace_sequencer
    import spell_trace_sequencer_pkg::*;
#(
    parameter int unsigned STROKES       = 16,
    parameter int unsigned POS_POINTS    = DEF_POS_POINTS,
    parameter int unsigned NEG_POINTS    = DEF_NEG_POINTS,
    parameter int unsigned BONUS_POINTS  = DEF_BONUS_POINTS,
    parameter int unsigned POWER_SAMPLES = 8,
    localparam int IW = $clog2(STROKES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          sample,
    input  logic          in_trace,
    input  logic          power_up1,
    input  logic          power_up4,
    output logic          upd_valid,
    output logic          upd_add,
    output logic [31:0]   upd_amount,
    output logic [IW-1:0] stroke_idx,
    output logic [IW-1:0] hit_count,
    output logic [1:0]    power_mode,
    output logic          busy,
    output logic          done
);

    logic [1:0]    state;
    logic          in_trace_st;
    logic          accept;
    logic          power_req;
    logic          power_clear;
    logic [1:0]    req_mode;
    logic [IW-1:0] idx_next;

    assign in_trace_st = (state == ST_TRACE);
    assign accept      = in_trace_st && sample && !abort;
    assign power_req   = in_trace_st && !abort && (power_up1 || power_up4);
    assign power_clear = abort || (state == ST_IDLE && start);
    assign req_mode    = power_up1 ? MODE_BONUS : MODE_DOUBLE;
    assign idx_next    = stroke_idx + 1'b1;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FINISH) && !abort;

    spell_trace_sequencer_power_timer #(
        .POWER_SAMPLES(POWER_SAMPLES)
    ) u_power_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (power_clear),
        .load      (power_req),
        .load_mode (req_mode),
        .dec       (accept),
        .mode      (power_mode)
    );

    // The command uses the mode in force before any same-cycle power-up load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            upd_valid  <= 1'b0;
            upd_add    <= 1'b0;
            upd_amount <= 32'd0;
            stroke_idx <= '0;
            hit_count  <= '0;
        end else begin
            upd_valid <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state      <= ST_TRACE;
                            stroke_idx <= '0;
                            hit_count  <= '0;
                        end
                    end
                    ST_TRACE: begin
                        if (sample) begin
                            upd_valid  <= 1'b1;
                            upd_add    <= in_trace;
                            upd_amount <= stroke_amount(in_trace, power_mode,
                                                        32'(POS_POINTS), 32'(NEG_POINTS),
                                                        32'(BONUS_POINTS));
                            stroke_idx <= idx_next;
                            hit_count  <= hit_count + IW'(in_trace);
                            if (idx_next == IW'(STROKES)) begin
                                state <= ST_FINISH;
                            end
                        end
                    end
                    ST_FINISH: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spell_trace_sequencer.sv
// Directed bench for spell_trace_sequencer: a vector table for the basic
// command rules plus hand-written sequences for rounds, power timing and abort.
module tb_spell_trace_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic        sample;
    logic        in_trace;
    logic        power_up1;
    logic        power_up4;
    logic        upd_valid;
    logic        upd_add;
    logic [31:0] upd_amount;
    logic [4:0]  stroke_idx;
    logic [4:0]  hit_count;
    logic [1:0]  power_mode;
    logic        busy;
    logic        done;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        st, ab, sm, tr, p1, p4;
        logic        vld, add;
        logic [31:0] amt;
        logic [4:0]  idx, hit;
        logic [1:0]  mode;
        logic        bsy, dn;
    } vec_t;

    vec_t vecs[$];

    spell_trace_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .sample     (sample),
        .in_trace   (in_trace),
        .power_up1  (power_up1),
        .power_up4  (power_up4),
        .upd_valid  (upd_valid),
        .upd_add    (upd_add),
        .upd_amount (upd_amount),
        .stroke_idx (stroke_idx),
        .hit_count  (hit_count),
        .power_mode (power_mode),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic st, ab, sm, tr, p1, p4, vld, add,
        input int amt, idx, hit, mode,
        input logic bsy, dn
    );
        vec_t v;
        v.st = st; v.ab = ab; v.sm = sm; v.tr = tr; v.p1 = p1; v.p4 = p4;
        v.vld = vld; v.add = add; v.amt = 32'(amt);
        v.idx = 5'(idx); v.hit = 5'(hit); v.mode = 2'(mode);
        v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(
        input string tag, input logic vld, input logic add, input int amt,
        input int idx, input int hit, input int mode, input logic bsy, input logic dn
    );
        chk({tag, ".upd_valid"}, 32'(upd_valid), 32'(vld));
        if (vld) begin
            chk({tag, ".upd_add"}, 32'(upd_add), 32'(add));
            chk({tag, ".upd_amount"}, upd_amount, 32'(amt));
        end
        chk({tag, ".stroke_idx"}, 32'(stroke_idx), 32'(idx));
        chk({tag, ".hit_count"}, 32'(hit_count), 32'(hit));
        chk({tag, ".power_mode"}, 32'(power_mode), 32'(mode));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    // Drive one cycle of inputs, then look at the outputs 1ns after the edge.
    task automatic cyc(input logic st, ab, sm, tr, p1, p4);
        start = st; abort = ab; sample = sm; in_trace = tr;
        power_up1 = p1; power_up4 = p4;
        @(posedge clock);
        #1;
        start = 1'b0; abort = 1'b0; sample = 1'b0; in_trace = 1'b0;
        power_up1 = 1'b0; power_up4 = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        start = 1'b0; abort = 1'b0; sample = 1'b0; in_trace = 1'b0;
        power_up1 = 1'b0; power_up4 = 1'b0;

        //             st ab sm tr p1 p4 vld add amt idx hit mode bsy dn
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 300, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 100, 2, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 300, 3, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0,   0, 3, 2, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 450, 4, 3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 100, 5, 3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 450, 6, 4, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   0, 6, 4, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 600, 7, 5, 2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0,   0, 7, 5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 7, 5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,   0, 7, 5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 1, 300, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Table-driven basic rules
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].st, vecs[i].ab, vecs[i].sm, vecs[i].tr, vecs[i].p1, vecs[i].p4);
            check_outs($sformatf("vec%0d", i), vecs[i].vld, vecs[i].add, int'(vecs[i].amt),
                       int'(vecs[i].idx), int'(vecs[i].hit), int'(vecs[i].mode),
                       vecs[i].bsy, vecs[i].dn);
        end

        // Full round: 16 back-to-back hits, done with the last command
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 1, 0, 0);
            check_outs($sformatf("full.s%0d", i + 1), 1, 1, 300, i + 1, i + 1, 0, 1, (i == 15));
        end
        cyc(0, 0, 0, 0, 0, 0);
        check_outs("full.after", 0, 0, 0, 16, 16, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        check_outs("full.idle_sample", 0, 0, 0, 16, 16, 0, 0, 0);

        // Double mode lasts exactly 8 samples
        cyc(1, 0, 0, 0, 0, 0);
        check_outs("dbl.start", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check_outs("dbl.load", 0, 0, 0, 0, 0, 2, 1, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 1, 1, 0, 0);
            check_outs($sformatf("dbl.s%0d", i + 1), 1, 1, (i < 8) ? 600 : 300,
                       i + 1, i + 1, (i < 7) ? 2 : 0, 1, 0);
        end
        cyc(0, 1, 0, 0, 0, 0);

        // Bonus requested on a sampling cycle: that hit keeps the old mode
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
        check_outs("bon.same", 1, 1, 300, 1, 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 1, 0, 0);
            check_outs($sformatf("bon.s%0d", i + 1), 1, 1, 450, i + 2, i + 2,
                       (i < 7) ? 1 : 0, 1, 0);
        end
        cyc(0, 0, 1, 1, 0, 0);
        check_outs("bon.after", 1, 1, 300, 10, 10, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);

        // Abort on the 5th sample with bonus active
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, (i != 1), 0, 0);
            check_outs($sformatf("abt.s%0d", i + 1), 1, (i != 1), (i != 1) ? 450 : 100,
                       i + 1, (i == 0) ? 1 : i, 1, 1, 0);
        end
        cyc(0, 1, 1, 1, 0, 0);
        check_outs("abt.fifth", 0, 0, 0, 4, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check_outs("abt.idle", 0, 0, 0, 4, 3, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check_outs("abt.restart", 0, 0, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset between clock edges
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 0);
        check_outs("arst.before", 1, 1, 600, 1, 1, 2, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        check_outs("arst.async", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("arst.upd_add", 32'(upd_add), 32'd0);
        chk("arst.upd_amount", upd_amount, 32'd0);
        #2;
        reset = 1'b0;
        cyc(0, 0, 1, 1, 0, 0);
        check_outs("arst.after", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spell_trace_sequencer.md
Name: spell_trace_sequencer

Overview:
- Round controller in front of the score accumulator datapath.
- Sequences one spell-trace round of STROKES sampled strokes and tracks stroke index and hit count.
- Owns power-up timing: bonus mode and double mode.
- Issues one registered add/subtract command per sampled stroke; the accumulator consumes these commands and is responsible for clamping at zero.

Parameters:
- STROKES, 16, strokes per round (2..255)
- POS_POINTS, 300, points per hit
- NEG_POINTS, 100, points per miss
- BONUS_POINTS, 150, extra points per hit in bonus mode
- POWER_SAMPLES, 8, samples a power-up stays active (1..255)

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a round; honoured only in IDLE
- abort  in  1  end the round immediately; no update issued
- sample  in  1  stroke strobe, one-cycle pulse
- in_trace  in  1  stroke hit (1) or miss (0); qualified by sample
- power_up1  in  1  request bonus mode
- power_up4  in  1  request double mode
- upd_valid  out  1  one-cycle command pulse to the accumulator
- upd_add  out  1  1 = add upd_amount, 0 = subtract upd_amount
- upd_amount  out  32  command magnitude
- stroke_idx  out  $clog2(STROKES+1)  strokes sampled so far in this round
- hit_count  out  $clog2(STROKES+1)  hits so far in this round
- power_mode  out  2  0 = none, 1 = bonus, 2 = double
- busy  out  1  high in TRACE and FINISH
- done  out  1  one-cycle pulse at round completion

Behaviour:
- Reset values: every output is 0; state is IDLE; power counter is 0.
- State IDLE:
  - start goes to TRACE.
  - On entering TRACE, clear stroke_idx, hit_count, power_mode and the power counter.
  - sample, power_up1 and power_up4 are ignored in IDLE.
- State TRACE, on a cycle with sample=1:
  - Register a command; upd_valid is high on the next cycle, so latency is 1.
  - Hit with mode none: add POS_POINTS.
  - Hit with mode bonus: add POS_POINTS+BONUS_POINTS.
  - Hit with mode double: add 2*POS_POINTS.
  - Miss in any mode: upd_add=0, subtract NEG_POINTS.
  - stroke_idx increments; hit_count increments on a hit.
  - If the power counter is nonzero, it decrements; at 1->0, power_mode returns to none.
  - When the incremented stroke_idx equals STROKES, go to FINISH.
- State FINISH, one cycle:
  - done=1; this cycle coincides with upd_valid for the last stroke.
  - Then go to IDLE; stroke_idx and hit_count hold until the next start.
- Power-ups, honoured in TRACE only:
  - Load mode and set the counter to POWER_SAMPLES.
  - power_up1 has priority over power_up4 when both are asserted.
  - A new request while a mode is active replaces the mode and restarts the counter.
  - A request in the same cycle as sample: that sample uses the old mode and does not decrement the newly loaded counter.
- abort:
  - Goes to IDLE from any state and clears power_mode and the power counter.
  - A sample in the same cycle is dropped (no upd_valid).
  - A command already registered still pulses on the next cycle.
  - done is not asserted; abort has priority over start.
- Other rules:
  - start while busy is ignored.
  - A sample on the cycle start is accepted is ignored, because the block is still in IDLE.
  - Back-to-back samples every cycle are supported, with one command per sample.
- Arithmetic:
  - All amounts are computed at 32 bits, unsigned, from constant parameters; no saturation is needed here.
- Asynchronous reset mid-round:
  - Drops any pending command and returns every output to its reset value immediately.

Decomposition:
- Shared package (game_pkg):
  - state enum IDLE, TRACE, FINISH
  - power_mode encoding NONE=0, BONUS=1, DOUBLE=2
  - default point constants (300, 100, 150)
- One natural sub-module, power_timer: mode register plus down-counter, with load, decrement on sample, and clear.

Test Plan:
- Reset, start, then 16 hits on consecutive cycles:
  - 16 upd_valid pulses, each add 300.
  - done coincides with the 16th pulse.
  - hit_count=16; busy drops the next cycle.
- Start, then hit, miss, hit with no power-ups:
  - Commands are add 300, sub 100, add 300.
  - stroke_idx=3, hit_count=2.
- power_up4 in TRACE, then 9 hits:
  - First 8 hits add 600, the 9th adds 300.
  - power_mode is 2 for the first 8 samples, then 0.
- power_up1 and power_up4 asserted together, then 3 samples: hit, miss, hit:
  - Commands are add 450, sub 100, add 450.
- power_up1 in the same cycle as a hit sample (mode none), then 8 hits:
  - The same-cycle hit adds 300, the next 8 add 450, after which the mode is none.
- Abort:
  - Abort on the same cycle as the 5th sample: no 5th command, no done, busy=0 the next cycle.
  - Then start: stroke_idx=0 and power_mode=0.
  - Asserting reset mid-round clears all outputs without waiting for a clock edge.
